// File: rtl/array_stream_pkg.sv
// array_stream_pkg
//   Shared types and limits for the serial-to-array loader.
//   ld_state_t   : loader state (FILL collects bytes, HOLD presents a frame)
//   LD_DEPTH_MAX : largest supported frame depth
//   ld_elem_t    : default frame element type (one byte)
package array_stream_pkg;

  typedef enum logic {FILL, HOLD} ld_state_t;

  parameter int unsigned LD_DEPTH_MAX = 64;

  typedef logic [7:0] ld_elem_t;

endpackage

// File: rtl/array_stream_loader.sv
// array_stream_loader
//   Collects one byte per valid/ready handshake into a DEPTH-element shift
//   array (element 0 = newest). A full frame, or an early flush, closes the
//   frame. The array, its wrap-around byte sum and the byte count are then
//   held stable until the consumer takes them.
//
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active high
//   in_valid   : upstream byte valid
//   in_data    : upstream byte
//   in_ready   : loader accepts a byte this cycle (FILL)
//   flush      : close the current frame early (sampled only in FILL)
//   arr_o      : frame array, element 0 newest
//   sum_o      : modulo-2^W sum of the frame bytes
//   cnt_o      : number of bytes in the frame
//   out_valid  : frame complete and held (HOLD)
//   out_ready  : consumer accepts the frame
module array_stream_loader
  import array_stream_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = $bits(ld_elem_t)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [W-1:0]                 in_data,
  output logic                         in_ready,
  input  logic                         flush,
  output logic [W-1:0]                 arr_o [DEPTH-1:0],
  output logic [W-1:0]                 sum_o,
  output logic [$clog2(DEPTH+1)-1:0]   cnt_o,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int unsigned CW = $clog2(DEPTH+1);

  if (DEPTH < 2 || DEPTH > LD_DEPTH_MAX) begin : g_bad_depth
    $error("array_stream_loader: DEPTH out of range");
  end

  ld_state_t       state_q, state_d;
  logic [W-1:0]    arr_q [DEPTH-1:0];
  logic [W-1:0]    arr_d [DEPTH-1:0];
  logic [W-1:0]    sum_q, sum_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Handshake flags come straight from the state register: no input reaches
  // them combinationally.
  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == HOLD);

  assign arr_o = arr_q;
  assign sum_o = sum_q;
  assign cnt_o = cnt_q;

  always_comb begin
    state_d = state_q;
    arr_d   = arr_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      FILL: begin
        if (in_valid) begin
          arr_d[0] = in_data;
          for (int i = 1; i < DEPTH; i++) arr_d[i] = arr_q[i-1];
          sum_d = sum_q + in_data;
          cnt_d = cnt_q + CW'(1);
        end
        // Compare the pre-increment count so DEPTH = 2^n never has to fit
        // in a post-increment compare. A flush only closes a non-empty
        // frame, counting the byte accepted on the same edge.
        if ((in_valid && cnt_q == CW'(DEPTH-1)) ||
            (flush && (cnt_q != '0 || in_valid)))
          state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          state_d = FILL;
          arr_d   = '{default: '0};
          sum_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      arr_q   <= '{default: '0};
      sum_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      arr_q   <= arr_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_array_stream_loader.sv
// tb_array_stream_loader
//   Table-driven full-frame checks, hand-written corner sequences and a
//   randomized run checked against a frame-queue reference model.
module tb_array_stream_loader;

  localparam int DEPTH = 8;
  localparam int W     = 8;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, flush, out_ready;
  logic [W-1:0]  in_data;
  logic          in_ready, out_valid;
  logic [W-1:0]  arr_o [DEPTH-1:0];
  logic [W-1:0]  sum_o;
  logic [CW-1:0] cnt_o;

  int tests = 0;
  int fails = 0;

  // Reference model: bytes of the current frame in arrival order, plus
  // whether the frame is closed and being presented.
  logic [W-1:0] mq [$];
  bit           m_held;

  always #5 clk = ~clk;

  array_stream_loader #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .flush(flush), .arr_o(arr_o), .sum_o(sum_o),
    .cnt_o(cnt_o), .out_valid(out_valid), .out_ready(out_ready)
  );

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         f;
    logic         r;
    logic         exp_ov;
    logic         exp_ir;
    logic [W-1:0] exp_sum;
    int           exp_cnt;
    logic [W-1:0] exp_arr0;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] m_arr(input int i);
    int k = mq.size();
    return (i < k) ? mq[k-1-i] : '0;
  endfunction

  function automatic logic [W-1:0] m_sum();
    int s = 0;
    foreach (mq[j]) s += mq[j];
    return W'(s);
  endfunction

  task automatic check_model(input string tag);
    bit bad = 0;
    int bi = 0;
    chk({tag, " out_valid"}, out_valid, m_held);
    chk({tag, " in_ready"}, in_ready, !m_held);
    chk({tag, " cnt"}, cnt_o, mq.size());
    chk({tag, " sum"}, sum_o, m_sum());
    for (int i = 0; i < DEPTH; i++)
      if (!bad && arr_o[i] !== m_arr(i)) begin bad = 1; bi = i; end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL %s arr[%0d]: got %0h, expected %0h", tag, bi, arr_o[bi], m_arr(bi));
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare after.
  task automatic cycle(input string tag, input logic v, input logic [W-1:0] d,
                       input logic f, input logic r);
    in_valid = v; in_data = d; flush = f; out_ready = r;
    @(posedge clk);
    if (!m_held) begin
      if (v) mq.push_back(d);
      if (mq.size() == DEPTH || (f && mq.size() > 0)) m_held = 1;
    end else if (r) begin
      mq.delete();
      m_held = 0;
    end
    #1;
    check_model(tag);
  endtask

  vec_t tbl [$];

  initial begin
    vec_t e;
    rst = 1'b1; in_valid = 0; in_data = '0; flush = 0; out_ready = 0;
    m_held = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset in_ready", in_ready, 1);
    chk("reset cnt", cnt_o, 0);
    chk("reset sum", sum_o, 0);
    chk("reset arr7", arr_o[7], 0);
    rst = 1'b0;

    // Full frame table: bytes 1..8, 5 hold cycles (one offering a byte and
    // a flush, both ignored), then release.
    for (int i = 1; i <= 8; i++) begin
      e = '{1'b1, W'(i), 1'b0, 1'b0, (i == 8), (i != 8), W'(i*(i+1)/2), i, W'(i)};
      tbl.push_back(e);
    end
    for (int i = 0; i < 4; i++) tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'd36, 8, 8'd8});
    tbl.push_back('{1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 1'b0, 8'd36, 8, 8'd8});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 0, 8'd0});
    foreach (tbl[t]) begin
      cycle("tbl", tbl[t].v, tbl[t].d, tbl[t].f, tbl[t].r);
      chk($sformatf("tbl%0d out_valid", t), out_valid, tbl[t].exp_ov);
      chk($sformatf("tbl%0d in_ready", t), in_ready, tbl[t].exp_ir);
      chk($sformatf("tbl%0d sum", t), sum_o, tbl[t].exp_sum);
      chk($sformatf("tbl%0d cnt", t), cnt_o, tbl[t].exp_cnt);
      chk($sformatf("tbl%0d arr0", t), arr_o[0], tbl[t].exp_arr0);
      if (t == 7)
        for (int i = 0; i < 8; i++) chk($sformatf("full arr%0d", 7-i), arr_o[7-i], i+1);
      if (t == 13) chk("release arr7", arr_o[7], 0);
    end

    // Sum wrap
    for (int i = 0; i < 8; i++) cycle("wrap", 1, 8'hFF, 0, 0);
    chk("wrap sum", sum_o, 8'hF8);
    chk("wrap cnt", cnt_o, 8);
    cycle("wrap rel", 0, 0, 0, 1);

    // Flush together with the last byte
    cycle("flush", 1, 8'h0A, 0, 0);
    cycle("flush", 1, 8'h0B, 0, 0);
    cycle("flush", 1, 8'h0C, 1, 0);
    chk("flush out_valid", out_valid, 1);
    chk("flush arr2", arr_o[2], 8'h0A);
    chk("flush arr1", arr_o[1], 8'h0B);
    chk("flush arr0", arr_o[0], 8'h0C);
    chk("flush arr3", arr_o[3], 0);
    chk("flush arr7", arr_o[7], 0);
    chk("flush cnt", cnt_o, 3);
    chk("flush sum", sum_o, 8'h21);
    cycle("flush rel", 0, 0, 0, 1);

    // Empty flush is ignored
    cycle("eflush", 0, 8'h77, 1, 0);
    chk("eflush out_valid", out_valid, 0);
    chk("eflush in_ready", in_ready, 1);
    cycle("eflush2", 0, 8'h00, 0, 0);
    chk("eflush2 out_valid", out_valid, 0);

    // Flush on the very first byte of a frame
    cycle("flush1", 1, 8'h5A, 1, 0);
    chk("flush1 cnt", cnt_o, 1);
    chk("flush1 out_valid", out_valid, 1);
    cycle("flush1 rel", 0, 0, 0, 1);

    // Random gaps, flushes and back-pressure
    for (int n = 0; n < 400; n++)
      cycle("rand", ($urandom_range(0, 2) != 0), W'($urandom),
            ($urandom_range(0, 11) == 0), ($urandom_range(0, 3) == 0));
    while (m_held) cycle("drain", 1, W'($urandom), 0, 1);

    // Asynchronous reset mid-frame
    for (int i = 0; i < 4; i++) cycle("prerst", 1, W'(8'h30 + i), 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst out_valid", out_valid, 0);
    chk("arst in_ready", in_ready, 1);
    chk("arst cnt", cnt_o, 0);
    chk("arst sum", sum_o, 0);
    chk("arst arr3", arr_o[3], 0);
    chk("arst arr0", arr_o[0], 0);
    mq.delete(); m_held = 0;
    in_valid = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) cycle("postrst", 1, W'($urandom), 0, 0);
    chk("postrst cnt", cnt_o, 8);
    chk("postrst out_valid", out_valid, 1);
    cycle("postrst rel", 0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
